// File: rtl/multiplier2.sv
// rtl/multiplier2.sv - sequential radix-2 shift-add signed/unsigned multiplier
module multiplier2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signedOp,
  input  logic [WIDTH-1:0] multiplicandIn,
  input  logic [WIDTH-1:0] multiplierIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] productHigh,
  output logic [WIDTH-1:0] productLow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  // Magnitude datapath: acc carries one extra bit so the add never loses its carry.
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   low;
  logic [WIDTH:0]     acc;
  logic               neg_result;
  logic [CW-1:0]      count;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] full;
  logic [2*WIDTH-1:0] result;

  // Operand sign detection, partial-product add and final conditional negate.
  // A most-negative operand negates to itself, which is already the right
  // magnitude when read unsigned, so it needs no special handling.
  always_comb begin
    a_neg  = signedOp & multiplicandIn[WIDTH-1];
    b_neg  = signedOp & multiplierIn[WIDTH-1];
    sum    = low[0] ? ({1'b0, acc[WIDTH-1:0]} + {1'b0, mag_a}) : acc;
    full   = {acc[WIDTH-1:0], low};
    result = neg_result ? (~full + 1'b1) : full;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and busy flag.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, shift-add iterations, result register and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_a       <= '0;
      low         <= '0;
      acc         <= '0;
      neg_result  <= 1'b0;
      count       <= '0;
      productHigh <= '0;
      productLow  <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            mag_a      <= a_neg ? (~multiplicandIn + 1'b1) : multiplicandIn;
            low        <= b_neg ? (~multiplierIn + 1'b1) : multiplierIn;
            neg_result <= signedOp & (multiplicandIn[WIDTH-1] ^ multiplierIn[WIDTH-1]);
            acc        <= '0;
            count      <= '0;
          end
        end
        RUN: begin
          acc   <= {1'b0, sum[WIDTH:1]};
          low   <= {sum[0], low[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        FIX: begin
          productHigh <= result[2*WIDTH-1:WIDTH];
          productLow  <= result[WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier2.sv
// tb/tb_multiplier2.sv - randomized and directed self-checking bench for multiplier2
module tb_multiplier2;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signedOp;
  logic [31:0] multiplicandIn;
  logic [31:0] multiplierIn;
  logic        busy;
  logic        done;
  logic [31:0] productHigh;
  logic [31:0] productLow;

  int checks = 0;
  int errors = 0;

  multiplier2 #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .signedOp       (signedOp),
    .multiplicandIn (multiplicandIn),
    .multiplierIn   (multiplierIn),
    .busy           (busy),
    .done           (done),
    .productHigh    (productHigh),
    .productLow     (productLow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: launches one operation and follows it to done.
  task automatic op(input bit s, input logic [31:0] a, input logic [31:0] b,
                    input int poke, input string tag);
    logic [63:0] exp;
    int cycles;
    int busy_cnt;
    exp = ref_mul(s, a, b);
    start = 1'b1;
    signedOp = s;
    multiplicandIn = a;
    multiplierIn = b;
    @(negedge clk);
    start = 1'b0;
    signedOp = 1'($urandom);
    multiplicandIn = $urandom;
    multiplierIn = $urandom;
    cycles = 1;
    busy_cnt = 0;
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
      start = (cycles == poke);
      if (start) begin
        multiplicandIn = $urandom;
        multiplierIn = $urandom;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(cycles), 64'd34);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " product"}, {productHigh, productLow}, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    reset = 1'b1;
    start = 1'b0;
    signedOp = 1'b0;
    multiplicandIn = '0;
    multiplierIn = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", {productHigh, productLow}, 64'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle done", 64'(done), 64'd0);
    end

    op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "unsigned_max");
    check("unsigned_max const", {productHigh, productLow}, 64'hFFFFFFFE_00000001);
    @(negedge clk);
    check("done one cycle", 64'(done), 64'd0);
    check("product hold", {productHigh, productLow}, 64'hFFFFFFFE_00000001);

    op(1'b1, 32'hFFFFFFFF, 32'h00000001, 0, "signed_m1x1");
    check("signed_m1x1 const", {productHigh, productLow}, 64'hFFFFFFFF_FFFFFFFF);
    op(1'b0, 32'hFFFFFFFF, 32'h00000001, 0, "unsigned_ffx1");
    check("unsigned_ffx1 const", {productHigh, productLow}, 64'h00000000_FFFFFFFF);
    op(1'b1, 32'h80000000, 32'h80000000, 0, "most_neg_sq");
    check("most_neg_sq const", {productHigh, productLow}, 64'h40000000_00000000);
    op(1'b1, 32'h80000000, 32'h00000001, 0, "most_neg_x1");
    check("most_neg_x1 const", {productHigh, productLow}, 64'hFFFFFFFF_80000000);
    op(1'b1, 32'h00000000, 32'hFFFFFFFE, 0, "zero_signed");
    check("zero_signed const", {productHigh, productLow}, 64'd0);
    op(1'b1, 32'h12345678, 32'hFEDCBA98, 10, "start_ignored");
    op(1'b0, 32'hDEADBEEF, 32'h00C0FFEE, 0, "back_to_back");

    start = 1'b1;
    signedOp = 1'b1;
    multiplicandIn = 32'hAAAA5555;
    multiplierIn = 32'h13572468;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort product", {productHigh, productLow}, 64'd0);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("abort no_done", 64'(done), 64'd0);
    end
    op(1'b0, 32'd7, 32'd6, 0, "after_abort");
    check("after_abort const", {productHigh, productLow}, 64'd42);

    for (int i = 0; i < 400; i++) begin
      rs = 1'($urandom);
      ra = ($urandom_range(7, 0) == 0) ? 32'h80000000 : $urandom;
      rb = ($urandom_range(7, 0) == 0) ? 32'hFFFFFFFF : $urandom;
      op(rs, ra, rb, 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
